// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GRANT_W_DEF = idx_w(4);

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection of the first valid requester after rr_last.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   rr_last_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_valid_o
);

    logic [IDX_W-1:0] idx_s;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx_s       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx_s       = IDX_W'((int'(rr_last_i) + i) % NUM_REQ);
            winner_o    = valid_i[idx_s] ? idx_s : winner_o;
            any_valid_o = any_valid_o | valid_i[idx_s];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port among NUM_REQ requesters.
// Optional ack watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int ADDR_W      = ADDR_W_DEF,
    parameter  int DATA_W      = DATA_W_DEF,
    parameter  int TIMEOUT_CYC = 256,
    localparam int IDX_W       = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic [NUM_REQ-1:0]        req_avail,
    input  logic [NUM_REQ-1:0]        req_r_en,
    input  logic [NUM_REQ-1:0]        req_w_en,
    input  logic [NUM_REQ*ADDR_W-1:0] req_ptr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_r_en,
    output logic                      mem_w_en,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      err
);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  valid_s;
    logic [NUM_REQ-1:0]  req_done_q, req_done_d;
    logic [IDX_W-1:0]    win_s;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [IDX_W-1:0]    rr_last_q, rr_last_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
    logic                mem_r_en_q, mem_r_en_d;
    logic                mem_w_en_q, mem_w_en_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                any_valid_s, grant_s, ack_ok_s, timeout_s, complete_s;

    assign valid_s    = req_avail & (req_r_en | req_w_en);
    assign grant_s    = (state_q == IDLE) && any_valid_s;
    assign ack_ok_s   = (state_q == ISSUE) && mem_ack;
    assign complete_s = ack_ok_s || timeout_s;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid_i     (valid_s),
        .rr_last_i   (rr_last_q),
        .winner_o    (win_s),
        .any_valid_o (any_valid_s)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // An ack arriving in the expiry cycle takes precedence over the timeout.
    assign timeout_s = (state_q == ISSUE) && !mem_ack && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog next value: cleared on grant, counts while waiting in ISSUE.
    always_comb begin
        if (grant_s) begin
            wd_d = '0;
        end else if (state_q == ISSUE) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic [31:0] timeout_unused_s;
    assign timeout_unused_s = 32'(TIMEOUT_CYC);
    assign timeout_s        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        case (state_q)
            IDLE:    state_d = grant_s ? ISSUE : IDLE;
            ISSUE:   state_d = complete_s ? RELEASE : ISSUE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values: latch the pick at grant, retire it on ack or timeout.
    always_comb begin
        grant_id_d  = grant_id_q;
        rr_last_d   = rr_last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_r_en_d  = mem_r_en_q;
        mem_w_en_d  = mem_w_en_q;
        req_done_d  = '0;
        req_rdata_d = '0;
        busy_d      = (state_d != IDLE);
        err_d       = err_q | (mem_ack && (state_q != ISSUE));
        if (grant_s) begin
            grant_id_d  = win_s;
            mem_addr_d  = req_ptr[int'(win_s)*ADDR_W +: ADDR_W];
            mem_wdata_d = req_wdata[int'(win_s)*DATA_W +: DATA_W];
            mem_w_en_d  = req_w_en[win_s];
            mem_r_en_d  = ~req_w_en[win_s];
            err_d       = err_d | (req_r_en[win_s] & req_w_en[win_s]);
        end else if (complete_s) begin
            mem_r_en_d             = 1'b0;
            mem_w_en_d             = 1'b0;
            req_done_d[grant_id_q] = 1'b1;
            req_rdata_d            = (ack_ok_s && mem_r_en_q) ? mem_rdata : '0;
            rr_last_d              = grant_id_q;
            err_d                  = err_d | timeout_s;
        end else begin
            req_done_d = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            grant_id_q  <= '0;
            rr_last_q   <= IDX_W'(NUM_REQ - 1);
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            req_done_q  <= '0;
            req_rdata_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            grant_id_q  <= grant_id_d;
            rr_last_q   <= rr_last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            req_done_q  <= req_done_d;
            req_rdata_q <= req_rdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign grant_id  = grant_id_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_r_en  = mem_r_en_q;
    assign mem_w_en  = mem_w_en_q;
    assign req_done  = req_done_q;
    assign req_rdata = req_rdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
